// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters with request-side x/y and
// latency-matched sync/blank plus registered RGB towards the DAC.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_LAT   = 0,
  parameter int CW        = 8
) (
  input  logic          vgaclk,
  input  logic          reset_b,
  input  logic          en,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          req,
  output logic          frame_start,
  output logic          line_start,
  input  logic [3*CW-1:0] rgb_in,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          de,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int D = PIX_LAT + 1;
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_err
    $error("vga_timing_gen: H_TOT/V_TOT must not exceed 1024");
  end
  if (PIX_LAT < 0 || PIX_LAT > 15) begin : g_lat_err
    $error("vga_timing_gen: PIX_LAT must be 0..15");
  end
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [3*D-1:0]    pipe_q, pipe_d;
  logic [3*CW-1:0]   rgb_q, rgb_d;
  logic [3*D+2:0]    chain;
  logic [2:0]        raw, tap, out;
  logic              h_end, v_end, hs, vs;
  // Each pipeline slot is {hs, vs, de}, active-high; polarity applied only at the pins.
  always_comb begin
    h_end = int'(hcnt_q) == H_TOT - 1;
    v_end = int'(vcnt_q) == V_TOT - 1;
    hcnt_d = (!en || h_end) ? '0 : hcnt_q + HW'(1);
    vcnt_d = (!en || (h_end && v_end)) ? '0 : vcnt_q + VW'(h_end);
    req = en && int'(hcnt_q) < H_ACTIVE && int'(vcnt_q) < V_ACTIVE;
    hs = en && int'(hcnt_q) >= H_ACTIVE + H_FP && int'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC;
    vs = en && int'(vcnt_q) >= V_ACTIVE + V_FP && int'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC;
    x = req ? 10'(hcnt_q) : '0;
    y = req ? 10'(vcnt_q) : '0;
    frame_start = en && hcnt_q == '0 && vcnt_q == '0;
    line_start = en && hcnt_q == '0;
    raw = {hs, vs, req};
    chain = {pipe_q, raw};
    tap = chain[3*PIX_LAT +: 3];
    out = chain[3*D +: 3];
    pipe_d = chain[3*D-1:0];
    rgb_d = tap[0] ? rgb_in : '0;
    hsync = out[2] ? HSYNC_POL : !HSYNC_POL;
    vsync = out[1] ? VSYNC_POL : !VSYNC_POL;
    sync_b = !(out[2] || out[1]);
    de = out[0];
    {r, g, b} = rgb_q;
  end
  always_ff @(posedge vgaclk) begin
    if (!reset_b) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      pipe_q <= '0;
      rgb_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      pipe_q <= pipe_d;
      rgb_q <= rgb_d;
    end
  end
endmodule
